// File: rtl/dag3_pack_pkg.sv
// Shared types and constants for the DAG3 result packer.
package dag3_pack_pkg;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DROP_W = 8;

  function automatic int SAMPLE_W(input int bits);
    return bits + 1;
  endfunction

endpackage

// File: rtl/dag3_pack_fifo.sv
// DEPTH-entry synchronous FIFO of packed {count, data} words.
module dag3_pack_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic          accept
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [DW-1:0] mem [DEPTH];
  logic          do_pop;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign accept = push && (!full || do_pop);
  assign rdata  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dag3_result_packer.sv
// Packs warm-up-filtered DAG3 result samples into words and buffers them for a ready/valid consumer.
module dag3_result_packer
  import dag3_pack_pkg::*;
#(
  parameter int BITS   = 2,
  parameter int PACK   = 4,
  parameter int DEPTH  = 4,
  parameter int WARMUP = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               in_valid,
  input  logic [BITS-1:0]                    res0,
  input  logic                               res1,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PACK*SAMPLE_W(BITS)-1:0]     out_data,
  output logic [$clog2(PACK):0]              out_count,
  output logic                               overflow,
  output logic [DROP_W-1:0]                  drop_count
);

  localparam int W     = SAMPLE_W(BITS);
  localparam int DATA_W = PACK * W;
  localparam int CNT_W = $clog2(PACK) + 1;
  localparam int WCW   = $clog2(WARMUP + 1);

  state_t              state_q, state_d;
  logic [WCW-1:0]      warm_cnt;
  logic [DATA_W-1:0]   pack_q, pack_d, merged;
  logic [CNT_W-1:0]    idx_q, idx_d, idx_inc;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic                accept;
  logic [CNT_W+DATA_W-1:0] head;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= WARM;
      warm_cnt <= '0;
      pack_q   <= '0;
      idx_q    <= '0;
    end else begin
      state_q <= state_d;
      pack_q  <= pack_d;
      idx_q   <= idx_d;
      if (state_q == WARM) warm_cnt <= warm_cnt + 1'b1;
    end
  end

  // Flush is judged on the index after this cycle's sample has been merged.
  always_comb begin
    state_d = state_q;
    merged  = pack_q;
    idx_inc = idx_q;
    push    = 1'b0;
    if (state_q == WARM) begin
      if (warm_cnt == WCW'(WARMUP - 1)) state_d = RUN;
    end else begin
      if (in_valid) begin
        for (int unsigned i = 0; i < PACK; i++) begin
          if (idx_q == CNT_W'(i)) merged[i*W +: W] = {res1, res0};
        end
        idx_inc = idx_q + 1'b1;
      end
      if (idx_inc == CNT_W'(PACK)) push = 1'b1;
      else if (flush && (idx_inc != '0)) push = 1'b1;
    end
    pack_d = push ? '0 : merged;
    idx_d  = push ? '0 : idx_inc;
  end

  assign pop = !empty && out_ready;

  dag3_pack_fifo #(
    .DW    (CNT_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   ({idx_inc, merged}),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .accept  (accept)
  );

  assign out_valid = !empty;
  assign out_count = head[CNT_W+DATA_W-1:DATA_W];
  assign out_data  = head[DATA_W-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (push && !accept) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_dag3_result_packer.sv
// Scoreboard bench for dag3_result_packer with default parameters.
module tb_dag3_result_packer;

  localparam int WARMUP = 4;

  typedef struct {
    logic [2:0]  cnt;
    logic [11:0] data;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [1:0]  res0;
  logic        res1;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [2:0]  out_count;
  logic        overflow;
  logic [7:0]  drop_count;

  int passed = 0;
  int total  = 0;

  exp_t        mq[$];
  logic [11:0] mword;
  int          midx;
  int          warm_edges;
  logic        movf;
  int          mdrop;

  dag3_result_packer #(
    .BITS   (2),
    .PACK   (4),
    .DEPTH  (4),
    .WARMUP (WARMUP)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .res0       (res0),
    .res1       (res1),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    mq.delete();
    mword      = '0;
    midx       = 0;
    warm_edges = 0;
    movf       = 1'b0;
    mdrop      = 0;
  endtask

  // Drives one cycle and advances the reference model across the edge.
  task automatic cyc(input logic v, input logic [2:0] s, input logic fl);
    bit   pop;
    bit   push;
    exp_t e;
    in_valid = v;
    res0     = s[1:0];
    res1     = s[2];
    flush    = fl;
    pop      = out_ready && (mq.size() > 0);
    push     = 0;
    e.cnt    = '0;
    e.data   = '0;
    if (warm_edges >= WARMUP) begin
      if (v) begin
        mword[midx*3 +: 3] = s;
        midx++;
      end
      if (midx == 4) begin
        push  = 1;
        e.cnt = 3'd4;
      end else if (fl && midx > 0) begin
        push  = 1;
        e.cnt = 3'(midx);
      end
      e.data = mword;
      if (push) begin
        mword = '0;
        midx  = 0;
      end
    end
    warm_edges++;
    @(posedge clock);
    #1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < 4) mq.push_back(e);
      else begin
        movf = 1'b1;
        if (mdrop < 255) mdrop++;
      end
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    res0      = '0;
    res1      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #3;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else passed++;
    total++; if (drop_count !== 8'd0) $display("FAIL reset_drop got=%0d exp=0", drop_count); else passed++;
    total++; if (out_data !== 12'h000 || out_count !== 3'd0)
      $display("FAIL reset_data got=%h/%0d exp=000/0", out_data, out_count); else passed++;
    repeat (2) @(posedge clock);
    release_reset();
  endtask

  task automatic test_warmup();
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 3'(k), 1'b0);
      if (k == 7) begin
        total++; if (out_valid !== 1'b0) $display("FAIL warm_early_valid got=%b exp=0", out_valid); else passed++;
      end
    end
    total++; if (out_valid !== 1'b1) $display("FAIL warm_valid got=%b exp=1", out_valid); else passed++;
    total++; if (out_data !== 12'h1F5 || out_count !== 3'd4)
      $display("FAIL warm_word got=%h/%0d exp=1f5/4", out_data, out_count); else passed++;
    out_ready = 1'b1;
    while (mq.size() > 0) begin
      total++; if (out_data !== mq[0].data || out_count !== mq[0].cnt)
        $display("FAIL warm_drain got=%h/%0d exp=%h/%0d", out_data, out_count, mq[0].data, mq[0].cnt); else passed++;
      cyc(1'b0, 3'd0, 1'b0);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_word();
    cyc(1'b1, 3'b001, 1'b0);
    cyc(1'b1, 3'b010, 1'b0);
    cyc(1'b1, 3'b011, 1'b0);
    total++; if (out_valid !== 1'b0) $display("FAIL full_early got=%b exp=0", out_valid); else passed++;
    cyc(1'b1, 3'b100, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 12'h8D1 || out_count !== 3'd4)
      $display("FAIL full_word got=%b/%h/%0d exp=1/8d1/4", out_valid, out_data, out_count); else passed++;
    cyc(1'b0, 3'd0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 12'h8D1 || out_count !== 3'd4)
      $display("FAIL full_hold got=%b/%h/%0d exp=1/8d1/4", out_valid, out_data, out_count); else passed++;
    out_ready = 1'b1;
    cyc(1'b0, 3'd0, 1'b0);
    out_ready = 1'b0;
    total++; if (out_valid !== (mq.size() > 0)) $display("FAIL full_popped got=%b exp=%b", out_valid, mq.size() > 0); else passed++;
  endtask

  task automatic test_flush();
    cyc(1'b1, 3'b111, 1'b0);
    cyc(1'b1, 3'b101, 1'b0);
    cyc(1'b0, 3'b000, 1'b1);
    total++; if (out_data !== 12'h02F || out_count !== 3'd2)
      $display("FAIL flush_partial got=%h/%0d exp=02f/2", out_data, out_count); else passed++;
    cyc(1'b0, 3'b000, 1'b1);
    cyc(1'b1, 3'b011, 1'b1);
    out_ready = 1'b1;
    while (mq.size() > 0) begin
      total++; if (out_valid !== 1'b1 || out_data !== mq[0].data || out_count !== mq[0].cnt)
        $display("FAIL flush_drain got=%b/%h/%0d exp=1/%h/%0d", out_valid, out_data, out_count, mq[0].data, mq[0].cnt); else passed++;
      cyc(1'b0, 3'd0, 1'b0);
    end
    total++; if (out_valid !== 1'b0) $display("FAIL flush_empty got=%b exp=0", out_valid); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int w = 0; w < 5; w++)
      for (int l = 0; l < 4; l++)
        cyc(1'b1, 3'(w + l), 1'b0);
    total++; if (overflow !== 1'b1 || overflow !== movf)
      $display("FAIL ovf_flag got=%b exp=1", overflow); else passed++;
    total++; if (drop_count !== 8'd1 || drop_count !== 8'(mdrop))
      $display("FAIL ovf_drop got=%0d exp=1", drop_count); else passed++;
    total++; if (mq.size() !== 4) $display("FAIL ovf_model_depth got=%0d exp=4", mq.size()); else passed++;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      total++; if (out_valid !== 1'b1 || out_data !== mq[0].data || out_count !== mq[0].cnt)
        $display("FAIL ovf_drain%0d got=%b/%h/%0d exp=1/%h/%0d", n, out_valid, out_data, out_count, mq[0].data, mq[0].cnt); else passed++;
      cyc(1'b0, 3'd0, 1'b0);
    end
    total++; if (out_valid !== 1'b0) $display("FAIL ovf_empty got=%b exp=0", out_valid); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_push_pop_full();
    for (int w = 0; w < 4; w++)
      for (int l = 0; l < 4; l++)
        cyc(1'b1, 3'(3 * w + l + 1), 1'b0);
    cyc(1'b1, 3'b110, 1'b0);
    cyc(1'b1, 3'b101, 1'b0);
    cyc(1'b1, 3'b100, 1'b0);
    out_ready = 1'b1;
    total++; if (out_data !== mq[0].data) $display("FAIL ppf_head got=%h exp=%h", out_data, mq[0].data); else passed++;
    cyc(1'b1, 3'b011, 1'b0);
    out_ready = 1'b0;
    total++; if (drop_count !== 8'd1 || drop_count !== 8'(mdrop))
      $display("FAIL ppf_drop got=%0d exp=1", drop_count); else passed++;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      total++; if (out_valid !== 1'b1 || out_data !== mq[0].data || out_count !== mq[0].cnt)
        $display("FAIL ppf_drain%0d got=%b/%h/%0d exp=1/%h/%0d", n, out_valid, out_data, out_count, mq[0].data, mq[0].cnt); else passed++;
      cyc(1'b0, 3'd0, 1'b0);
    end
    total++; if (out_valid !== 1'b0) $display("FAIL ppf_empty got=%b exp=0", out_valid); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      cyc(1'b1, 3'(k * 5 + 2), 1'b0);
      total++; if (out_valid !== (mq.size() > 0))
        $display("FAIL b2b_valid%0d got=%b exp=%b", k, out_valid, mq.size() > 0); else passed++;
      if (mq.size() > 0) begin
        total++; if (out_data !== mq[0].data || out_count !== mq[0].cnt)
          $display("FAIL b2b_data%0d got=%h/%0d exp=%h/%0d", k, out_data, out_count, mq[0].data, mq[0].cnt); else passed++;
      end
    end
    cyc(1'b0, 3'd0, 1'b1);
    cyc(1'b0, 3'd0, 1'b0);
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int n = 0; n < 10; n++) cyc(1'b1, 3'(n), 1'b0);
    total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got=%b exp=1", out_valid); else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0)
      $display("FAIL mid_reset got=%b/%b/%0d exp=0/0/0", out_valid, overflow, drop_count); else passed++;
    release_reset();
    for (int k = 1; k <= 8; k++) cyc(1'b1, 3'(8 - k), 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 12'h053 || out_count !== 3'd4 || out_data !== mq[0].data)
      $display("FAIL mid_rewarm got=%b/%h/%0d exp=1/053/4", out_valid, out_data, out_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_full_word();
    test_flush();
    test_overflow();
    test_push_pop_full();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
